mul_controller: RTL and testbench
=================================

MUL_CONTROLLER -- requirements
Module: mul_controller

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: startE  in  1  multiply instruction present in Execute stage; held high while the pipeline is stalled.
REQ-004 SHALL have port: mul_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-005 SHALL have port: opA, opB  in  32 each  rs1/rs2 operand values, post-forwarding.
REQ-006 SHALL have port: waddrE  in  5  destination register of the Execute instruction.
REQ-007 SHALL have port: kill  in  1  abort the in-flight operation (trap/redirect).
REQ-008 SHALL have port: mul_use  out  1  stall/flush request to the hazard unit.
REQ-009 SHALL have port: mul_valid  out  1  one-cycle result strobe.
REQ-010 SHALL have port: mul_result  out  32  selected product half.
REQ-011 SHALL have port: mul_waddr  out  5  destination register latched at start.
REQ-012 SHALL have port: mul_busy  out  1  high in CALC.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-014 IDLE: on startE=1 and kill=0, SHALL latch opA, opB, mul_op and waddrE, clear the 6-bit iteration counter, and enter CALC.
REQ-015 mul_use SHALL be combinationally high in IDLE when startE=1 and kill=0, high throughout CALC, and low in DONE.
REQ-016 CALC: SHALL perform one shift-add step per cycle on operand magnitudes and increment the counter; after the step at count 31 it SHALL enter DONE.
REQ-017 Sign rules: MUL and MULH SHALL treat both operands as signed; MULHSU SHALL treat opA as signed and opB as unsigned; MULHU SHALL treat both as unsigned. The 64-bit magnitude product SHALL be two's-complement negated when exactly one signed operand is negative.
REQ-018 mul_result SHALL be product[31:0] for MUL and product[63:32] for the other three ops.
REQ-019 DONE: mul_valid=1 for exactly one cycle, with mul_result and mul_waddr stable; startE SHALL be ignored; next state is IDLE.
REQ-020 Latency: startE accepted at cycle T SHALL give mul_valid at T+33; mul_use SHALL be high for cycles T..T+32.
REQ-021 Back-to-back: a new startE in the IDLE cycle following DONE SHALL start a new operation with no bubble beyond that IDLE cycle.
REQ-022 kill in any state SHALL force IDLE on the next edge, with no mul_valid for the aborted operation; kill takes priority over startE in the same cycle.
REQ-023 Operand 0 or operand 0x80000000 SHALL need no special case; the result SHALL be bit-exact per RV32M.
REQ-024 mul_result and mul_waddr SHALL hold their last values outside DONE; consumers SHALL qualify them with mul_valid.

Reset
REQ-025 rst=1 SHALL asynchronously force: state IDLE, counter 0, accumulator and operand registers 0, mul_valid 0, mul_busy 0, mul_result 0, mul_waddr 0.
REQ-026 mul_use SHALL be 0 during reset regardless of startE.
REQ-027 Reset asserted mid-CALC SHALL discard the operation, and no mul_valid SHALL follow after release.

Structure
REQ-028 Shared package mul_pkg SHALL hold: mul_op_t enum (MUL, MULH, MULHSU, MULHU), mul_state_t enum (IDLE, CALC, DONE), XLEN=32, MUL_CYCLES=32.
REQ-029 The accumulator, shift registers and final sign correction SHALL live in one sub-module, mul_datapath; mul_controller SHALL hold the FSM, the counter and the handshake.

Verification
REQ-030 MUL opA=7, opB=6, startE held at T -> mul_valid at T+33, mul_result=42, mul_use high T..T+32.
REQ-031 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU on the same operands -> 0xFFFFFFFE.
REQ-032 MULHSU opA=0xFFFFFFFF, opB=2 -> 0xFFFFFFFF; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-033 kill at T+10 -> IDLE at T+11, mul_use=0 at T+11, no mul_valid through T+40.
REQ-034 rst pulse at T+20 -> all outputs 0 immediately, no mul_valid after release.
REQ-035 Two MUL ops back-to-back (3x5 with waddr 4, then 9x9 with waddr 5) -> valid at T+33 (15, waddr 4) and at T+67 (81, waddr 5).

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
//   mul_op_t    : operation encoding carried on the mul_op port
//   mul_state_t : controller FSM states
//   XLEN        : operand width
//   MUL_CYCLES  : number of shift-add steps per multiply
package mul_pkg;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = 32;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath for the iterative multiplier.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   load         : capture operand magnitudes, sign and half select
//   step         : perform one shift-add step
//   op_in        : operation (selects operand signedness and result half)
//   op_a, op_b   : raw operands
//   result_next  : selected, sign-corrected half of the product as it will
//                  stand after the current step
module mul_datapath
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  mul_op_t         op_in,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result_next
);

  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              hi_q, hi_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod;

  // Only MULHU treats opA as unsigned; only MUL/MULH treat opB as signed.
  // Negating 0x80000000 yields 0x80000000, which read as unsigned is the
  // correct magnitude 2^31, so no special case is needed.
  always_comb begin
    a_neg = (op_in != MULHU) && op_a[XLEN-1];
    b_neg = ((op_in == MUL) || (op_in == MULH)) && op_b[XLEN-1];
    mag_a = a_neg ? (~op_a + 1'b1) : op_a;
    mag_b = b_neg ? (~op_b + 1'b1) : op_b;
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    if (load) begin
      mcand_d  = {{XLEN{1'b0}}, mag_a};
      mplier_d = mag_b;
      acc_d    = '0;
      neg_d    = a_neg ^ b_neg;
      hi_d     = (op_in != MUL);
    end else if (step) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // Sign correction looks at acc_d so the controller can register the
  // final result on the same edge as the last step.
  always_comb begin
    prod        = neg_q ? (~acc_d + 1'b1) : acc_d;
    result_next = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
    end
  end

endmodule

// File: rtl/mul_controller.sv
// Iterative RV32M multiply controller: FSM, step counter and pipeline
// handshake around mul_datapath.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   startE             : multiply present in Execute (held while stalled)
//   mul_op             : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   opA, opB           : forwarded rs1/rs2 values
//   waddrE             : destination register of the Execute instruction
//   kill               : abort the in-flight operation
//   mul_use            : stall request to the hazard unit
//   mul_valid          : one-cycle result strobe
//   mul_result         : selected product half (held outside DONE)
//   mul_waddr          : destination register of the result (held)
//   mul_busy           : high while iterating
module mul_controller
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [1:0]      mul_op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      waddrE,
  input  logic            kill,
  output logic            mul_use,
  output logic            mul_valid,
  output logic [XLEN-1:0] mul_result,
  output logic [4:0]      mul_waddr,
  output logic            mul_busy
);

  mul_state_t      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [4:0]      waddr_lat_q, waddr_lat_d;
  logic [XLEN-1:0] mul_result_q, mul_result_d;
  logic [4:0]      mul_waddr_q, mul_waddr_d;

  logic            use_c;
  logic            dp_load, dp_step;
  logic [XLEN-1:0] dp_result;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    waddr_lat_d  = waddr_lat_q;
    mul_result_d = mul_result_q;
    mul_waddr_d  = mul_waddr_q;
    use_c        = 1'b0;
    dp_load      = 1'b0;
    dp_step      = 1'b0;

    case (state_q)
      IDLE: begin
        if (startE && !kill) begin
          use_c       = 1'b1;
          dp_load     = 1'b1;
          cnt_d       = '0;
          waddr_lat_d = waddrE;
          state_d     = CALC;
        end
      end
      CALC: begin
        use_c   = 1'b1;
        dp_step = 1'b1;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'(MUL_CYCLES - 1)) begin
          state_d      = DONE;
          // Published outputs change only on entry to DONE and then hold.
          mul_result_d = dp_result;
          mul_waddr_d  = waddr_lat_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything, including a pending completion.
    if (kill) begin
      state_d      = IDLE;
      mul_result_d = mul_result_q;
      mul_waddr_d  = mul_waddr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      waddr_lat_q  <= '0;
      mul_result_q <= '0;
      mul_waddr_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      waddr_lat_q  <= waddr_lat_d;
      mul_result_q <= mul_result_d;
      mul_waddr_q  <= mul_waddr_d;
    end
  end

  mul_datapath u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (dp_load),
    .step        (dp_step),
    .op_in       (mul_op_t'(mul_op)),
    .op_a        (opA),
    .op_b        (opB),
    .result_next (dp_result)
  );

  // startE may be high while reset is held; never request a stall then.
  assign mul_use    = use_c & ~rst;
  assign mul_valid  = (state_q == DONE) & ~kill;
  assign mul_busy   = (state_q == CALC);
  assign mul_result = mul_result_q;
  assign mul_waddr  = mul_waddr_q;

endmodule

// File: tb/tb_mul_controller.sv
module tb_mul_controller;

  logic        clk;
  logic        rst;
  logic        startE;
  logic [1:0]  mul_op;
  logic [31:0] opA, opB;
  logic [4:0]  waddrE;
  logic        kill;
  logic        mul_use, mul_valid, mul_busy;
  logic [31:0] mul_result;
  logic [4:0]  mul_waddr;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [31:0] last_res;
  logic [4:0]  last_wa;

  mul_controller dut (
    .clk        (clk),
    .rst        (rst),
    .startE     (startE),
    .mul_op     (mul_op),
    .opA        (opA),
    .opB        (opB),
    .waddrE     (waddrE),
    .kill       (kill),
    .mul_use    (mul_use),
    .mul_valid  (mul_valid),
    .mul_result (mul_result),
    .mul_waddr  (mul_waddr),
    .mul_busy   (mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference: widen each operand to 64 bits per its signedness and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = (op != 2'b11) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (op[1] == 1'b0) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(sa * sb);
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Issue one op at the next falling edge (cycle T) and follow it to T+33.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa);
    logic [31:0] exp;
    exp = ref_mul(op, a, b);
    @(negedge clk);
    startE = 1'b1; mul_op = op; opA = a; opB = b; waddrE = wa;
    #1;
    chk("use_T", mul_use, 1);
    chk("busy_T", mul_busy, 0);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (c < 33) begin
        chk("use_calc", mul_use, 1);
        chk("busy_calc", mul_busy, 1);
        chk("valid_calc", mul_valid, 0);
        // Operands wander while stalled; the result must use latched copies.
        opA = $urandom; opB = $urandom; mul_op = 2'($urandom); waddrE = 5'($urandom);
      end else begin
        chk("valid_done", mul_valid, 1);
        chk("use_done", mul_use, 0);
        chk("busy_done", mul_busy, 0);
        chk("result", mul_result, exp);
        chk("waddr", mul_waddr, wa);
      end
    end
    $display("op=%0d a=%08h b=%08h wa=%0d -> result=%08h exp=%08h", op, a, b, wa,
             mul_result, exp);
    startE   = 1'b0;
    last_res = exp;
    last_wa  = wa;
  endtask

  task automatic idle_hold;
    @(negedge clk);
    chk("valid_idle", mul_valid, 0);
    chk("use_idle", mul_use, 0);
    chk("hold_result", mul_result, last_res);
    chk("hold_waddr", mul_waddr, last_wa);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; startE = 1'b1; mul_op = 2'b00; opA = 32'd1; opB = 32'd1;
    waddrE = 5'd1; kill = 1'b0;
    last_res = '0; last_wa = '0;
    repeat (2) @(negedge clk);
    chk("rst_use", mul_use, 0);
    chk("rst_valid", mul_valid, 0);
    chk("rst_busy", mul_busy, 0);
    chk("rst_result", mul_result, 0);
    chk("rst_waddr", mul_waddr, 0);
    startE = 1'b0;
    rst = 1'b0;
    $display("reset released");

    run_op(2'b00, 32'd7, 32'd6, 5'd3);
    idle_hold();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 5'd9);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd10);
    chk("mulh_min_const", mul_result, 32'h4000_0000);
    idle_hold();

    // Back-to-back: second issue lands in the IDLE cycle right after DONE.
    run_op(2'b00, 32'd3, 32'd5, 5'd4);
    run_op(2'b00, 32'd9, 32'd9, 5'd5);
    idle_hold();

    // Kill at T+10.
    @(negedge clk);
    startE = 1'b1; mul_op = 2'b00; opA = 32'd11; opB = 32'd13; waddrE = 5'd6;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0; startE = 1'b0;
    #1;
    chk("kill_use", mul_use, 0);
    chk("kill_busy", mul_busy, 0);
    for (int c = 11; c <= 40; c++) begin
      if (c > 11) @(negedge clk);
      chk("kill_novalid", mul_valid, 0);
    end
    chk("kill_hold_result", mul_result, last_res);
    $display("kill test done");

    // kill and startE together in IDLE: no start.
    @(negedge clk);
    startE = 1'b1; kill = 1'b1;
    #1;
    chk("kill_prio_use", mul_use, 0);
    @(negedge clk);
    startE = 1'b0; kill = 1'b0;
    chk("kill_prio_busy", mul_busy, 0);
    $display("kill priority test done");

    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom), pick_operand(), pick_operand(), 5'($urandom));
      if ($urandom_range(0, 1) == 1) idle_hold();
    end

    // Reset pulse mid-CALC at T+20.
    @(negedge clk);
    startE = 1'b1; mul_op = 2'b11; opA = 32'hDEAD_BEEF; opB = 32'h1234_5678; waddrE = 5'd12;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_use", mul_use, 0);
    chk("midrst_valid", mul_valid, 0);
    chk("midrst_busy", mul_busy, 0);
    chk("midrst_result", mul_result, 0);
    chk("midrst_waddr", mul_waddr, 0);
    @(negedge clk);
    rst = 1'b0; startE = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("postrst_novalid", mul_valid, 0);
      chk("postrst_busy", mul_busy, 0);
    end
    $display("mid-calc reset test done");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
